// File: rtl/bp_cache_req_arbiter.sv
// bp_cache_req_arbiter: shares one cache-service request port between I$ and D$, holding the grant until completion.
// Define BP_CACHE_ARB_DCACHE_PRIORITY_EN for fixed D$ priority; the default build is round-robin.
module bp_cache_req_arbiter #(
    parameter int req_width_p      = 96,
    parameter int metadata_width_p = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [req_width_p-1:0]      icache_req_i,
    input  logic                        icache_req_v_i,
    output logic                        icache_req_ready_o,
    input  logic [metadata_width_p-1:0] icache_req_metadata_i,
    input  logic                        icache_req_metadata_v_i,
    output logic                        icache_req_complete_o,
    input  logic [req_width_p-1:0]      dcache_req_i,
    input  logic                        dcache_req_v_i,
    output logic                        dcache_req_ready_o,
    input  logic [metadata_width_p-1:0] dcache_req_metadata_i,
    input  logic                        dcache_req_metadata_v_i,
    output logic                        dcache_req_complete_o,
    output logic [req_width_p-1:0]      req_o,
    output logic                        req_v_o,
    input  logic                        req_ready_i,
    output logic [metadata_width_p-1:0] req_metadata_o,
    output logic                        req_metadata_v_o,
    input  logic                        req_complete_i,
    output logic                        grant_dcache_o,
    output logic                        busy_o
);
    typedef enum logic [1:0] {e_idle, e_meta, e_complete} state_e;
    state_e state_r, state_n;
    logic grant_r, idle, pick_d, owner, win_v, xfer, own_meta_v, done;

`ifdef BP_CACHE_ARB_DCACHE_PRIORITY_EN
    assign pick_d = dcache_req_v_i;
`else
    // On a tie the requester not granted last wins
    assign pick_d = dcache_req_v_i & (~icache_req_v_i | ~grant_r);
`endif

    assign idle       = (state_r == e_idle);
    assign owner      = idle ? pick_d : grant_r;
    assign win_v      = pick_d ? dcache_req_v_i : icache_req_v_i;
    assign xfer       = idle & ~reset_i & win_v & req_ready_i;
    assign own_meta_v = owner ? dcache_req_metadata_v_i : icache_req_metadata_v_i;
    assign done       = ~reset_i & req_complete_i & ((state_r == e_complete) | ((state_r == e_meta) & own_meta_v));

    assign req_o              = pick_d ? dcache_req_i : icache_req_i;
    assign req_v_o            = idle & ~reset_i & win_v;
    assign icache_req_ready_o = idle & ~reset_i & ~pick_d & req_ready_i;
    assign dcache_req_ready_o = idle & ~reset_i & pick_d & req_ready_i;
    assign req_metadata_o     = owner ? dcache_req_metadata_i : icache_req_metadata_i;
    assign req_metadata_v_o   = ~reset_i & own_meta_v & (xfer | (state_r == e_meta));
    assign icache_req_complete_o = done & ~grant_r;
    assign dcache_req_complete_o = done & grant_r;
    assign grant_dcache_o     = grant_r;
    assign busy_o             = ~idle;

    always_comb begin
        state_n = state_r;
        if (xfer)
            state_n = own_meta_v ? e_complete : e_meta;
        else if (state_r == e_meta && own_meta_v)
            state_n = req_complete_i ? e_idle : e_complete;
        else if (state_r == e_complete && req_complete_i)
            state_n = e_idle;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            grant_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (xfer)
                grant_r <= pick_d;
        end
    end
endmodule

// File: doc/bp_cache_req_arbiter.md
# bp_cache_req_arbiter

Shares one LCE/UCE cache-service request port between the core's I$ and D$ request channels. Each cache presents its request, metadata and completion handshakes separately; the arbiter selects one, forwards the request and its metadata downstream, and holds the grant until the downstream engine signals completion. Completion is then routed back to the owning cache. It sits between the core and a single shared coherence/uncached engine.

## Interface
- req_width_p, 96: width of a packed cache request (identical for I$ and D$)
- metadata_width_p, 8: width of packed request metadata
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- icache_req_i  in  req_width_p  I$ request
- icache_req_v_i  in  1  I$ request valid
- icache_req_ready_o  out  1  I$ request accepted when high with valid
- icache_req_metadata_i  in  metadata_width_p  I$ metadata
- icache_req_metadata_v_i  in  1  I$ metadata valid
- icache_req_complete_o  out  1  one-cycle pulse: I$ request finished
- dcache_req_i, dcache_req_v_i, dcache_req_ready_o, dcache_req_metadata_i, dcache_req_metadata_v_i, dcache_req_complete_o: D$ equivalents, same widths and meanings
- req_o  out  req_width_p  forwarded request
- req_v_o  out  1  forwarded request valid
- req_ready_i  in  1  downstream ready
- req_metadata_o  out  metadata_width_p  forwarded metadata
- req_metadata_v_o  out  1  forwarded metadata valid
- req_complete_i  in  1  downstream completion pulse
- grant_dcache_o  out  1  current or last owner (1 = D$)
- busy_o  out  1  a request is outstanding (state != e_idle)

## Operation
- States: e_idle, e_meta, e_complete.
- e_idle: the arbiter picks a winner among valid requesters.
  - Round-robin: on a tie, the requester not granted last wins.
  - req_o and req_v_o mirror the winner combinationally.
  - Only the winner's ready_o equals req_ready_i; the loser's ready_o is 0.
  - Transfer occurs when the winner's v_i & req_ready_i. Transfer latches the owner and updates the last-grant pointer.
- Next state after a transfer:
  - Go to e_meta.
  - If the owner's metadata_v_i is high in the same cycle, forward it and go directly to e_complete.
- e_meta: req_metadata_o and req_metadata_v_o mirror the owner's metadata; the non-owner's metadata_v_i is ignored. On metadata valid, go to e_complete.
- e_complete: on req_complete_i, pulse the owner's complete_o and go to e_idle. If req_complete_i arrives in e_meta together with metadata_v, forward the metadata, pulse complete, and go to e_idle.
- req_complete_i in e_idle is ignored; no complete pulse is produced.
- Outside e_idle, req_v_o = 0 and both ready_o = 0.
- Reset mid-operation: the state returns to e_idle and the outstanding grant is dropped. No complete pulse is produced for it.

## Timing
- Reset values: state e_idle, grant_dcache_o = 0 (so D$ wins the first tie), busy_o = 0, complete pulses 0.
- While reset_i is high, all valid/ready outputs are 0.
- Request path: zero-cycle combinational forwarding. There is no buffering.
- Minimum request-to-next-grant turnaround is 2 cycles (accept plus metadata/complete in the same cycle, then next accept).
- Completion pulse: combinational from req_complete_i, exactly 1 cycle.
- Requesters may drop or change v_i freely while not accepted.

## Configuration
- BP_CACHE_ARB_DCACHE_PRIORITY_EN
  - Defined: fixed priority, D$ always beats I$ on a tie, and the last-grant pointer is unused.
  - Undefined: round-robin as described.

## Test plan
- Single I$ request, req_ready_i = 1, metadata at cycle +1, complete at +3 -> req_v_o in cycle 0; icache_req_complete_o pulses at +3; busy_o is 1 in cycles 1–3.
- Both valid for 4 back-to-back transactions, round-robin build -> grant order D, I, D, I. With BP_CACHE_ARB_DCACHE_PRIORITY_EN defined -> D, D, D, D.
- D$ wins while req_ready_i = 0 for 3 cycles -> no transfer and both ready_o = 0 throughout. Transfer occurs in the first cycle req_ready_i = 1.
- Request accepted with metadata_v the same cycle, complete the next cycle -> state goes e_idle → e_complete → e_idle, and a new request is accepted in the third cycle.
- Stray req_complete_i in e_idle, and I$ metadata_v while D$ owns the grant -> no complete pulses and no metadata forwarded.
- reset_i asserted in e_complete -> next cycle busy_o = 0 and grant_dcache_o = 0; a subsequent req_complete_i produces no pulse.
